multi_port_table: RTL and testbench
===================================

MULTI_PORT_TABLE -- requirements
Module: multi_port_table

Interface
REQ-001 Parameter DATA_W, default 8: width in bits of each table entry.
REQ-002 Parameter ADDR_W, default 8: width in bits of every address bus.
REQ-003 Parameter DEPTH, default 256: number of table entries, 1..2**ADDR_W.
REQ-004 Parameter NUM_RD, default 4: number of independent read ports, 1..8.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 init_req  input  1  one-cycle pulse requesting re-initialization of the whole table.
REQ-008 ready  output  1  high when the table is initialized and accepting accesses.
REQ-009 rd_en  input  NUM_RD  per-port read request.
REQ-010 rd_addr  input  NUM_RD*ADDR_W  per-port read address; port p occupies bits [p*ADDR_W +: ADDR_W].
REQ-011 rd_data  output  NUM_RD*DATA_W  per-port registered read data; port p occupies bits [p*DATA_W +: DATA_W].
REQ-012 rd_valid  output  NUM_RD  per-port one-cycle strobe qualifying rd_data.
REQ-013 wr_en  input  1  write request.
REQ-014 wr_addr  input  ADDR_W  write address.
REQ-015 wr_data  input  DATA_W  write data.

Function
REQ-016 The FSM SHALL have two states: INIT and RUN.
REQ-017 In INIT, an internal counter SHALL write entry i with value (i mod 2**DATA_W) at one entry per cycle, for i = 0..DEPTH-1.
REQ-018 In INIT, the transition to RUN SHALL occur on the cycle that writes entry DEPTH-1, so initialization takes exactly DEPTH cycles.
REQ-019 ready SHALL be 1 in RUN and 0 in INIT.
REQ-020 In RUN, init_req=1 SHALL move the FSM to INIT with the counter at 0; a wr_en in that same cycle SHALL be discarded.
REQ-021 In INIT, init_req SHALL restart the counter at 0.
REQ-022 In RUN, rd_en[p]=1 at edge k SHALL produce rd_valid[p]=1 and rd_data[p]=table[rd_addr[p]] after edge k+1; the latency is 1 cycle.
REQ-023 All NUM_RD ports SHALL be serviced in the same cycle with no arbitration, including when several ports request the same address.
REQ-024 rd_valid[p] SHALL be 0 in any cycle not following an accepted read.
REQ-025 rd_data[p] SHALL hold its last value while rd_valid[p]=0.
REQ-026 In INIT, rd_en SHALL be ignored: rd_valid stays 0 and rd_data is unchanged.
REQ-027 In RUN, wr_en=1 SHALL write wr_data to wr_addr at that clock edge.
REQ-028 In INIT, wr_en SHALL be ignored.
REQ-029 A read of an address >= DEPTH SHALL return 0 with rd_valid=1.
REQ-030 A write to an address >= DEPTH SHALL be ignored.
REQ-031 A same-cycle read and write to the same address SHALL follow REQ-040/REQ-041.

Reset
REQ-032 While reset=0, state SHALL be INIT, the counter 0, ready 0, rd_valid all 0, and rd_data all 0.
REQ-033 Reset SHALL act immediately, without waiting for clk.
REQ-034 Table storage SHALL NOT be reset directly; it is rewritten by INIT starting on the first rising edge after reset returns to 1.
REQ-035 Reset asserted mid-INIT or mid-RUN SHALL abort all activity; a full DEPTH-cycle INIT SHALL follow release.

Configuration
REQ-036 Macro WRITE_BYPASS_EN SHALL select the read-during-write behaviour.
REQ-037 With WRITE_BYPASS_EN defined, a read port whose rd_addr equals wr_addr while wr_en=1 in RUN SHALL return wr_data (new data).
REQ-038 With WRITE_BYPASS_EN undefined, the same collision SHALL return the pre-write table contents (old data).
REQ-039 In both configurations, the table SHALL hold wr_data after the edge.
REQ-040 (Collision rule, RUN state) rd_addr[p]==wr_addr with wr_en=1: new data if WRITE_BYPASS_EN is defined, old data otherwise.
REQ-041 (Collision rule, out-of-range) The collision rule SHALL NOT apply when wr_addr >= DEPTH; such a read returns 0.

Verification
REQ-042 Init timing (defaults): release reset -> ready rises after exactly 256 edges; rd_en[3]=1, addr 0x5A -> rd_valid[3]=1, rd_data 0x5A one cycle later.
REQ-043 Parallel reads: ports 0..3 read addresses 0x00, 0xFF, 0x10, 0x10 together -> all rd_valid=1 next cycle with 0x00, 0xFF, 0x10, 0x10.
REQ-044 Write then read: write 0xA5 to 0x20, read port 1 of 0x20 next cycle -> rd_data 0xA5; the same read issued in the write cycle returns 0x20 (bypass off) or 0xA5 (WRITE_BYPASS_EN on).
REQ-045 Re-init and blocked accesses: after REQ-044, pulse init_req -> ready=0 for 256 cycles, rd_en and wr_en ignored, then a read of 0x20 returns 0x20.
REQ-046 Mid-init reset: DEPTH=100, DATA_W=4, reset at init cycle 50 -> ready=0 and rd_valid=0 at once; after release ready rises after 100 edges; a read of 99 returns 3 and a read of 150 returns 0.

Source files
------------

// File: rtl/multi_port_table.sv
// Multi-read-port lookup table with a self-initializing INIT/RUN controller.
// Define WRITE_BYPASS_EN to forward same-cycle write data to colliding reads (default: old data).
module multi_port_table #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int NUM_RD = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       init_req,
  output logic                       ready,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_valid,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data
);

  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

`ifdef WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  state_e                    state_q, state_d;
  logic [ADDR_W-1:0]         cnt_q, cnt_d;
  logic [NUM_RD-1:0]         rd_valid_q, rd_valid_d;
  logic [NUM_RD*DATA_W-1:0]  rd_data_q, rd_data_d;

  logic [DATA_W-1:0]         mem_q [DEPTH];
  logic                      mem_we;
  logic [IDX_W-1:0]          mem_waddr;
  logic [DATA_W-1:0]         mem_wdata;
  logic                      wr_accept;
  logic [ADDR_W-1:0]         ra;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_LIM;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_we     = 1'b0;
    mem_waddr  = IDX_W'(cnt_q);
    mem_wdata  = DATA_W'(cnt_q);
    rd_valid_d = '0;
    rd_data_d  = rd_data_q;
    ra         = '0;
    // A write in the init_req cycle is dropped, so it must not feed the bypass either.
    wr_accept  = (state_q == ST_RUN) && wr_en && !init_req && in_range(wr_addr);

    case (state_q)
      ST_INIT: begin
        mem_we = 1'b1;
        if (init_req) begin
          cnt_d = '0;
        end else if (cnt_q == LAST_IDX) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end

      ST_RUN: begin
        if (init_req) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
        if (wr_accept) begin
          mem_we    = 1'b1;
          mem_waddr = IDX_W'(wr_addr);
          mem_wdata = wr_data;
        end
        for (int unsigned p = 0; p < NUM_RD; p++) begin
          if (rd_en[p]) begin
            ra            = rd_addr[p*ADDR_W +: ADDR_W];
            rd_valid_d[p] = 1'b1;
            if (!in_range(ra)) begin
              rd_data_d[p*DATA_W +: DATA_W] = '0;
            end else if (BYPASS && wr_accept && (ra == wr_addr)) begin
              rd_data_d[p*DATA_W +: DATA_W] = wr_data;
            end else begin
              rd_data_d[p*DATA_W +: DATA_W] = mem_q[IDX_W'(ra)];
            end
          end
        end
      end

      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Storage has no reset; the INIT sweep rewrites every entry after reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign ready    = (state_q == ST_RUN);
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_multi_port_table.sv
// Randomized self-checking bench for multi_port_table: default instance against a table model,
// plus a small DEPTH=100/DATA_W=4 instance for out-of-range and mid-init reset cases.
module tb_multi_port_table;

`ifdef WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        reset, init_req, ready, wr_en;
  logic [3:0]  rd_en, rd_valid;
  logic [31:0] rd_addr, rd_data;
  logic [7:0]  wr_addr, wr_data;

  logic        s_reset, s_init_req, s_ready, s_wr_en;
  logic [1:0]  s_rd_en, s_rd_valid;
  logic [15:0] s_rd_addr;
  logic [7:0]  s_rd_data, s_wr_addr;
  logic [3:0]  s_wr_data;

  multi_port_table dut (
    .clk(clk), .reset(reset), .init_req(init_req), .ready(ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  multi_port_table #(.DATA_W(4), .ADDR_W(8), .DEPTH(100), .NUM_RD(2)) dut_s (
    .clk(clk), .reset(s_reset), .init_req(s_init_req), .ready(s_ready),
    .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_valid(s_rd_valid),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: cycles left in initialization, table contents, expected read outputs.
  int         init_left;
  logic [7:0] tbl [256];
  logic [7:0] e_data [4];
  logic       e_valid [4];

  task automatic model_reset();
    init_left = 256;
    for (int p = 0; p < 4; p++) begin
      e_valid[p] = 1'b0;
      e_data[p]  = 8'h00;
    end
  endtask

  task automatic model_edge();
    logic [7:0] a;
    if (init_left > 0) begin
      for (int p = 0; p < 4; p++) e_valid[p] = 1'b0;
      if (init_req) init_left = 256;
      else begin
        init_left--;
        if (init_left == 0)
          for (int i = 0; i < 256; i++) tbl[i] = 8'(i);
      end
    end else begin
      for (int p = 0; p < 4; p++) begin
        if (rd_en[p]) begin
          a = rd_addr[p*8 +: 8];
          e_valid[p] = 1'b1;
          if (BYP && wr_en && !init_req && a == wr_addr) e_data[p] = wr_data;
          else e_data[p] = tbl[a];
        end else begin
          e_valid[p] = 1'b0;
        end
      end
      if (init_req) init_left = 256;
      else if (wr_en) tbl[wr_addr] = wr_data;
    end
  endtask

  task automatic check_big();
    check("ready", 32'(ready), (init_left == 0) ? 32'd1 : 32'd0);
    for (int p = 0; p < 4; p++) begin
      check($sformatf("rd_valid%0d", p), 32'(rd_valid[p]), 32'(e_valid[p]));
      check($sformatf("rd_data%0d", p), 32'(rd_data[p*8 +: 8]), 32'(e_data[p]));
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_big();
  endtask

  task automatic idle();
    init_req = 1'b0; rd_en = '0; wr_en = 1'b0;
    s_init_req = 1'b0; s_rd_en = '0; s_wr_en = 1'b0;
  endtask

  task automatic set_rd(input int p, input logic [7:0] a);
    rd_en[p] = 1'b1;
    rd_addr[p*8 +: 8] = a;
  endtask

  int n;

  initial begin
    reset = 1'b0; s_reset = 1'b0;
    idle();
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    s_rd_addr = '0; s_wr_addr = '0; s_wr_data = '0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_big();
    check("s_ready_rst", 32'(s_ready), 32'd0);
    check("s_rd_data_rst", 32'(s_rd_data), 32'd0);
    reset = 1'b1;

    n = 0;
    while (!ready && n < 1000) begin tick(); n++; end
    check("init_edges", n, 256);

    set_rd(3, 8'h5A); tick(); idle();
    check("first_read_valid3", 32'(rd_valid[3]), 32'd1);
    check("first_read_data3", 32'(rd_data[31:24]), 32'h5A);

    set_rd(0, 8'h00); set_rd(1, 8'hFF); set_rd(2, 8'h10); set_rd(3, 8'h10);
    tick(); idle();
    check("parallel_valid", 32'(rd_valid), 32'hF);
    check("parallel_data", rd_data, 32'h1010FF00);
    tick();

    wr_en = 1'b1; wr_addr = 8'h20; wr_data = 8'hA5; set_rd(1, 8'h20);
    tick(); idle();
    check("collide_data1", 32'(rd_data[15:8]), BYP ? 32'hA5 : 32'h20);
    set_rd(1, 8'h20); tick(); idle();
    check("after_write_data1", 32'(rd_data[15:8]), 32'hA5);

    init_req = 1'b1; tick(); idle();
    check("reinit_ready0", 32'(ready), 32'd0);
    n = 0;
    while (!ready && n < 1000) begin
      rd_en = 4'($urandom); rd_addr = $urandom;
      wr_en = 1'b1; wr_addr = 8'h20; wr_data = 8'($urandom);
      tick(); n++;
    end
    idle();
    check("reinit_len", n, 256);
    set_rd(1, 8'h20); tick(); idle();
    check("reinit_reread1", 32'(rd_data[15:8]), 32'h20);

    for (int c = 0; c < 1500; c++) begin
      if (c == 700) begin
        idle(); rd_en = 4'hF; tick();
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("midrun_rst_valid", 32'(rd_valid), 32'd0);
        check_big();
        @(posedge clk);
        #1 reset = 1'b1;
      end
      rd_en    = 4'($urandom);
      rd_addr  = $urandom;
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = ($urandom_range(0, 3) == 0) ? rd_addr[7:0] : 8'($urandom);
      wr_data  = 8'($urandom);
      init_req = ($urandom_range(0, 399) == 0);
      tick();
    end
    idle();

    s_reset = 1'b1;
    repeat (50) tick();
    check("s_mid_init_ready", 32'(s_ready), 32'd0);
    #2 s_reset = 1'b0;
    #1;
    check("s_rst_ready", 32'(s_ready), 32'd0);
    check("s_rst_valid", 32'(s_rd_valid), 32'd0);
    check("s_rst_data", 32'(s_rd_data), 32'd0);
    tick();
    s_reset = 1'b1;
    n = 0;
    while (!s_ready && n < 500) begin tick(); n++; end
    check("s_init_edges", n, 100);

    s_rd_en = 2'b11; s_rd_addr = {8'd150, 8'd99};
    tick(); idle();
    check("s_read_valid", 32'(s_rd_valid), 32'h3);
    check("s_read99", 32'(s_rd_data[3:0]), 32'd3);
    check("s_read150", 32'(s_rd_data[7:4]), 32'd0);

    s_wr_en = 1'b1; s_wr_addr = 8'd99; s_wr_data = 4'h9;
    s_rd_en = 2'b01; s_rd_addr = {8'd0, 8'd99};
    tick(); idle();
    check("s_collide99", 32'(s_rd_data[3:0]), BYP ? 32'd9 : 32'd3);
    check("s_collide_valid", 32'(s_rd_valid), 32'h1);

    s_wr_en = 1'b1; s_wr_addr = 8'd150; s_wr_data = 4'hF;
    s_rd_en = 2'b11; s_rd_addr = {8'd150, 8'd99};
    tick(); idle();
    check("s_after_write99", 32'(s_rd_data[3:0]), 32'd9);
    check("s_collide_oor", 32'(s_rd_data[7:4]), 32'd0);

    s_rd_en = 2'b10; s_rd_addr = {8'd150, 8'd37};
    tick(); idle();
    check("s_oor_ignored", 32'(s_rd_data[7:4]), 32'd0);
    check("s_hold_port0", 32'(s_rd_data[3:0]), 32'd9);
    check("s_valid_port1", 32'(s_rd_valid), 32'h2);

    s_rd_en = 2'b01;
    tick(); idle();
    check("s_read37", 32'(s_rd_data[3:0]), 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
